// File: rtl/rom_line_fill.sv
// -----------------------------------------------------------------------------
// rom_line_fill
//   Request/response line filler in front of the synchronous instruction ROM.
//   A request latches a line-aligned byte address. WORDS = LINE_WIDTH/RAM_WIDTH
//   ROM reads are then issued back to back, one per cycle. Each word's data is
//   written into its slot of the line one cycle after its read is issued. Words
//   whose byte address falls outside the ROM image read as zero and set
//   resp_err. The finished line is held until the consumer takes it. flush
//   abandons a fill or a pending response.
//
//   Ports
//     clk         clock
//     rstn        asynchronous active-low reset
//     flush       abort the current fill / drop the pending response
//     req_valid   line request valid
//     req_ready   block idle and able to accept a request (registered)
//     req_addr    byte address; bits below the line size are ignored
//     resp_valid  line response valid (registered)
//     resp_ready  consumer accepts the response
//     resp_data   assembled line, word i at [i*RAM_WIDTH +: RAM_WIDTH]
//     resp_addr   line-aligned byte address of the response
//     resp_err    at least one word was outside the ROM and zero-filled
//
// rom
//   Synchronous-read instruction ROM with one cycle of read latency. The
//   image is generated arithmetically (word k = IMAGE_BASE + k).
//   INIT_FILE names the image file that the production ROM loads.
//
//   Ports
//     clk   clock
//     addr  word index
//     dout  word at the address presented on the previous edge
// -----------------------------------------------------------------------------

module rom #(
    parameter int                   RAM_WIDTH  = 32,
    parameter int                   RAM_DEPTH  = 1024,
    parameter                       INIT_FILE  = "test.txt",
    parameter logic [RAM_WIDTH-1:0] IMAGE_BASE = RAM_WIDTH'(32'hA000_0000)
) (
    input  logic                         clk,
    input  logic [$clog2(RAM_DEPTH)-1:0] addr,
    output logic [RAM_WIDTH-1:0]         dout
);

    logic [RAM_WIDTH-1:0] dout_q;

    // Registered read: data for addr appears after the next edge.
    always_ff @(posedge clk) begin
        dout_q <= IMAGE_BASE + RAM_WIDTH'(addr);
    end

    assign dout = dout_q;

endmodule

module rom_line_fill #(
    parameter int                    RAM_WIDTH  = 32,
    parameter int                    LINE_WIDTH = 512,
    parameter int                    RAM_DEPTH  = 1024,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h0001_0094,
    parameter                        INIT_FILE  = "test.txt"
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  resp_err
);

    localparam int WORDS = LINE_WIDTH / RAM_WIDTH;
    localparam int WSH   = $clog2(RAM_WIDTH / 8);   // byte -> word shift
    localparam int CW    = $clog2(WORDS);           // slot index width
    localparam int RAW   = $clog2(RAM_DEPTH);       // ROM address width
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((LINE_WIDTH / 8) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    // One extra bit: the MSB set means every read of the line has been issued.
    logic [CW:0]           issue_q, issue_d;
    logic                  rd_vld_q, rd_vld_d;    // a ROM read is in flight
    logic                  rd_inv_q, rd_inv_d;    // that read is outside the image
    logic [CW-1:0]         rd_slot_q, rd_slot_d;  // slot the read lands in
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH:0]   byte_s;
    logic [ADDR_WIDTH:0]   idx_s;
    logic                  invalid_s;
    logic [RAW-1:0]        rom_addr_s;
    logic [RAM_WIDTH-1:0]  rom_dout_s;
    logic                  accept_s;
    logic                  issue_fire_s;
    logic                  last_wr_s;

    // Word address of the read being issued. The extra MSB catches a carry
    // past the top of the address space, which counts as outside the ROM.
    always_comb begin
        byte_s     = {1'b0, line_addr_q} + ((ADDR_WIDTH + 1)'(issue_q) << WSH);
        idx_s      = (byte_s - {1'b0, START_ADDR}) >> WSH;
        invalid_s  = byte_s[ADDR_WIDTH]
                   | (byte_s < {1'b0, START_ADDR})
                   | (idx_s >= (ADDR_WIDTH + 1)'(RAM_DEPTH));
        rom_addr_s = idx_s[RAW-1:0];
    end

    rom #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr_s),
        .dout (rom_dout_s)
    );

    assign accept_s     = (state_q == ST_IDLE) && req_valid && !flush;
    assign issue_fire_s = (state_q == ST_FILL) && !issue_q[CW];
    assign last_wr_s    = rd_vld_q && (rd_slot_q == CW'(WORDS - 1));

    // FSM state register and its registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // FSM next state; flush wins over acceptance and over the response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (last_wr_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the next state so they register with it.
    always_comb begin
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        case (state_d)
            ST_IDLE: req_ready_d  = 1'b1;
            ST_RESP: resp_valid_d = 1'b1;
            default: begin
                req_ready_d  = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Fill datapath: issue one read per cycle, write back the read of the
    // previous cycle. A flush only stops the pipeline; the line is kept.
    always_comb begin
        line_addr_d = line_addr_q;
        issue_d     = issue_q;
        rd_vld_d    = 1'b0;
        rd_inv_d    = rd_inv_q;
        rd_slot_d   = rd_slot_q;
        data_d      = data_q;
        err_d       = err_q;
        if (accept_s) begin
            line_addr_d = req_addr & ~LINE_MASK;
            issue_d     = '0;
            data_d      = '0;
            err_d       = 1'b0;
        end else if ((state_q == ST_FILL) && !flush) begin
            if (issue_fire_s) begin
                rd_vld_d  = 1'b1;
                rd_inv_d  = invalid_s;
                rd_slot_d = issue_q[CW-1:0];
                issue_d   = issue_q + (CW + 1)'(1);
            end else begin
                rd_vld_d  = 1'b0;
            end
            if (rd_vld_q) begin
                data_d[rd_slot_q*RAM_WIDTH +: RAM_WIDTH] = rd_inv_q ? '0 : rom_dout_s;
                err_d = err_q | rd_inv_q;
            end else begin
                err_d = err_q;
            end
        end else begin
            rd_vld_d = 1'b0;
        end
    end

    // Fill datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_addr_q <= '0;
            issue_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_inv_q    <= 1'b0;
            rd_slot_q   <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            line_addr_q <= line_addr_d;
            issue_q     <= issue_d;
            rd_vld_q    <= rd_vld_d;
            rd_inv_q    <= rd_inv_d;
            rd_slot_q   <= rd_slot_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_addr  = line_addr_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_rom_line_fill.sv
// Scoreboard bench for rom_line_fill with the default parameters
// (16 words of 32 bits, ROM word k = 32'hA000_0000 + k).
module tb_rom_line_fill;

    localparam int LW    = 512;
    localparam int AW    = 32;
    localparam int WORDS = 16;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [LW-1:0] resp_data;
    logic [AW-1:0] resp_addr;
    logic          resp_err;

    rom_line_fill dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [LW-1:0] data;
        logic [AW-1:0] addr;
        logic          err;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Hand-derived line: slots lead..lead+nvalid-1 hold first, first+1, ...; the rest are zero.
    function automatic logic [LW-1:0] mk_line(input logic [31:0] first, input int lead, input int nvalid);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (i >= lead && i < lead + nvalid) begin
                l[i*32 +: 32] = first + 32'(i - lead);
            end
        end
        return l;
    endfunction

    // Issue one request; if push, queue the expected response with its accept edge.
    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] ea,
                        input logic [LW-1:0] ed, input logic ee, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_wait", LW'(req_ready), LW'(1'b1));
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1;
        if (push) begin
            e.data = ed;
            e.addr = ea;
            e.err  = ee;
            e.acc  = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", LW'(q.size()), LW'(0));
    endtask

    // Monitor: latency on each rising resp_valid, contents on each handshake.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid && !prev && q.size() != 0) begin
                chk("latency", LW'(cyc - q[0].acc), LW'(WORDS + 1));
            end
            if (q.size() == 0) begin
                chk("unexpected_resp", LW'(resp_valid), LW'(1'b0));
            end else if (resp_valid && resp_ready) begin
                e = q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_addr", LW'(resp_addr), LW'(e.addr));
                chk("resp_err", LW'(resp_err), LW'(e.err));
            end
            prev = resp_valid;
        end
    end

    logic [LW-1:0] line1, line2, line3, line4, line6;

    initial begin : stim
        line1 = mk_line(32'hA000_000B, 0, 16);
        line2 = mk_line(32'hA000_0000, 5, 11);
        line3 = mk_line(32'hA000_03FB, 0, 5);
        line4 = mk_line(32'h0000_0000, 0, 0);
        line6 = mk_line(32'hA000_001B, 0, 16);

        rstn       = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", LW'(req_ready), LW'(1'b1));
        chk("rst_resp_valid", LW'(resp_valid), LW'(1'b0));
        chk("rst_resp_data", resp_data, LW'(0));
        chk("rst_resp_addr", LW'(resp_addr), LW'(0));
        chk("rst_resp_err", LW'(resp_err), LW'(1'b0));
        @(negedge clk);
        rstn = 1'b1;

        // In-image line, ROM start straddle, ROM end, below the image, unaligned address.
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b1);
        drain();
        send(32'h0001_0080, 32'h0001_0080, line2, 1'b1, 1'b1);
        drain();
        send(32'h0001_1080, 32'h0001_1080, line3, 1'b1, 1'b1);
        drain();
        send(32'h0000_0000, 32'h0000_0000, line4, 1'b1, 1'b1);
        drain();
        send(32'h0001_00C5, 32'h0001_00C0, line1, 1'b0, 1'b1);
        drain();

        // Back-pressure: response held for 10 cycles while a new request is ignored.
        resp_ready = 1'b0;
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (!resp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        req_valid = 1'b1;
        req_addr  = 32'h0001_0080;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", LW'(resp_valid), LW'(1'b1));
            chk("hold_req_ready", LW'(req_ready), LW'(1'b0));
            chk("hold_data", resp_data, line1);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("post_hs_req_ready", LW'(req_ready), LW'(1'b1));
        chk("post_hs_resp_valid", LW'(resp_valid), LW'(1'b0));
        repeat (25) @(negedge clk);
        drain();

        // Flush during FILL cycle 7: no response, idle next cycle, clean refill after.
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_req_ready", LW'(req_ready), LW'(1'b1));
        chk("flush_resp_valid", LW'(resp_valid), LW'(1'b0));
        repeat (25) @(negedge clk);
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b1);
        drain();

        // Reset mid-fill: idle at once, fill dropped, clean refill after.
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_req_ready", LW'(req_ready), LW'(1'b1));
        chk("mid_rst_resp_valid", LW'(resp_valid), LW'(1'b0));
        chk("mid_rst_resp_data", resp_data, LW'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b1);
        drain();

        // Back-to-back requests with the consumer always ready.
        send(32'h0001_00C0, 32'h0001_00C0, line1, 1'b0, 1'b1);
        send(32'h0001_0100, 32'h0001_0100, line6, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
